int_wb_arbiter: RTL and testbench

// Integer writeback stage directly downstream of the ALU/div execution unit.

---
 rtl/int_wb_arbiter_pkg.sv | 21 ++
 rtl/int_wb_arbiter_if.sv | 55 +++++
 rtl/int_wb_arbiter_kill_fifo.sv | 109 ++++++++++
 rtl/int_wb_arbiter.sv | 112 +++++++++++
 tb/tb_int_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_wb_arbiter_pkg.sv
// Shared types and widths for the integer writeback arbiter.
package wb_pkg;

  localparam int DEF_DATA_W = 65;
  localparam int DEF_BR_W   = 20;
  localparam int ROB_W      = 7;
  localparam int PREG_W     = 7;

  localparam logic [1:0] RT_FIX = 2'h0;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] pdst;
    logic [1:0]        dst_rtype;
  } wb_uop_t;

  function automatic logic writes_rf(input logic [1:0] rtype);
    return rtype == RT_FIX;
  endfunction

endpackage

// File: rtl/int_wb_arbiter_if.sv
// Bus bundle between the execute/secondary sources and the writeback arbiter.
interface int_wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BR_W   = DEF_BR_W
) ();

  logic              io_exe_valid;
  logic [ROB_W-1:0]  io_exe_rob_idx;
  logic [PREG_W-1:0] io_exe_pdst;
  logic [1:0]        io_exe_dst_rtype;
  logic [DATA_W-1:0] io_exe_data;

  logic              io_sec_valid;
  logic              io_sec_ready;
  logic [BR_W-1:0]   io_sec_br_mask;
  logic [ROB_W-1:0]  io_sec_rob_idx;
  logic [PREG_W-1:0] io_sec_pdst;
  logic [1:0]        io_sec_dst_rtype;
  logic [DATA_W-1:0] io_sec_data;

  logic [BR_W-1:0]   io_brupdate_b1_resolve_mask;
  logic [BR_W-1:0]   io_brupdate_b1_mispredict_mask;
  logic              io_flush;

  logic              io_wb_valid;
  logic              io_wb_rf_wen;
  logic [ROB_W-1:0]  io_wb_rob_idx;
  logic [PREG_W-1:0] io_wb_pdst;
  logic [1:0]        io_wb_dst_rtype;
  logic [DATA_W-1:0] io_wb_data;
  logic              io_wb_src;

  modport slave (
    input  io_exe_valid, io_exe_rob_idx, io_exe_pdst, io_exe_dst_rtype, io_exe_data,
    input  io_sec_valid, io_sec_br_mask, io_sec_rob_idx, io_sec_pdst, io_sec_dst_rtype,
    input  io_sec_data,
    input  io_brupdate_b1_resolve_mask, io_brupdate_b1_mispredict_mask, io_flush,
    output io_sec_ready,
    output io_wb_valid, io_wb_rf_wen, io_wb_rob_idx, io_wb_pdst, io_wb_dst_rtype,
    output io_wb_data, io_wb_src
  );

  modport master (
    output io_exe_valid, io_exe_rob_idx, io_exe_pdst, io_exe_dst_rtype, io_exe_data,
    output io_sec_valid, io_sec_br_mask, io_sec_rob_idx, io_sec_pdst, io_sec_dst_rtype,
    output io_sec_data,
    output io_brupdate_b1_resolve_mask, io_brupdate_b1_mispredict_mask, io_flush,
    input  io_sec_ready,
    input  io_wb_valid, io_wb_rf_wen, io_wb_rob_idx, io_wb_pdst, io_wb_dst_rtype,
    input  io_wb_data, io_wb_src
  );

endinterface

// File: rtl/int_wb_arbiter_kill_fifo.sv
// Small FIFO of secondary writebacks whose entries track branch masks and
// self-invalidate on mispredict; dead slots stay counted until popped.
module wb_kill_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BR_W   = DEF_BR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [BR_W-1:0]   resolve_mask,
  input  logic [BR_W-1:0]   mispredict_mask,
  input  logic              enq,
  input  wb_uop_t           enq_uop,
  input  logic [BR_W-1:0]   enq_br_mask,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output wb_uop_t           head_uop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_ok,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [BR_W-1:0]  mask_reg  [DEPTH];
  logic [BR_W-1:0]  mask_next [DEPTH];

  wb_uop_t           uop_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic slot_enq;
      assign slot_enq = enq && (tail_reg == PTR_W'(gi));
      // A slot killed this cycle keeps its place in the ring; only its valid drops.
      assign valid_next[gi] = flush    ? 1'b0 :
                              slot_enq ? 1'b1 :
                              valid_reg[gi] & ~|(mask_reg[gi] & mispredict_mask);
      assign mask_next[gi]  = slot_enq ? (enq_br_mask & ~resolve_mask)
                                       : (mask_reg[gi] & ~resolve_mask);
    end
  endgenerate

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign head_uop  = uop_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign head_ok   = ~empty & valid_reg[head_reg] & ~|(mask_reg[head_reg] & mispredict_mask);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (deq) head_next = head_reg + PTR_W'(1);
      if (enq) tail_next = tail_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mask_reg[i] <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      for (int i = 0; i < DEPTH; i++) mask_reg[i] <= mask_next[i];
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      uop_mem[tail_reg]  <= enq_uop;
      data_mem[tail_reg] <= enq_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(enq && full));
      assert (!(deq && empty));
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: exe response has absolute priority, secondary
// responses bypass when possible or queue in a kill-aware FIFO.
module int_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BR_W   = DEF_BR_W
) (
  input logic             clock,
  input logic             reset,
  int_wb_arbiter_if.slave bus
);

  wb_uop_t           exe_uop, sec_uop, head_uop;
  logic [DATA_W-1:0] head_data;
  logic              head_ok, fifo_empty, fifo_full;
  logic              exe_valid, sec_fire, sec_killed, sec_keep, sec_bypass;
  logic              enq, deq, head_dead, sel_head, wb_sel;

  wb_uop_t           wb_uop_reg, wb_uop_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic              wb_valid_reg, wb_rf_wen_reg, wb_src_reg, wb_src_next;

  assign exe_uop.rob_idx   = bus.io_exe_rob_idx;
  assign exe_uop.pdst      = bus.io_exe_pdst;
  assign exe_uop.dst_rtype = bus.io_exe_dst_rtype;
  assign sec_uop.rob_idx   = bus.io_sec_rob_idx;
  assign sec_uop.pdst      = bus.io_sec_pdst;
  assign sec_uop.dst_rtype = bus.io_sec_dst_rtype;

  assign exe_valid  = bus.io_exe_valid;
  assign sec_fire   = bus.io_sec_valid & bus.io_sec_ready;
  assign sec_killed = |(bus.io_sec_br_mask & bus.io_brupdate_b1_mispredict_mask);
  assign sec_keep   = sec_fire & ~sec_killed & ~bus.io_flush;
  assign sec_bypass = sec_keep & ~exe_valid & fifo_empty;
  assign enq        = sec_keep & ~sec_bypass;

  // Dead heads drain regardless of exe so they never block the queue.
  assign head_dead = ~fifo_empty & ~head_ok;
  assign deq       = head_dead | (head_ok & ~exe_valid);
  assign sel_head  = ~exe_valid & head_ok & ~bus.io_flush;
  assign wb_sel    = exe_valid | sel_head | sec_bypass;

  assign bus.io_sec_ready = reset & ~fifo_full;

  wb_kill_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .BR_W   (BR_W)
  ) u_fifo (
    .clock           (clock),
    .reset           (reset),
    .flush           (bus.io_flush),
    .resolve_mask    (bus.io_brupdate_b1_resolve_mask),
    .mispredict_mask (bus.io_brupdate_b1_mispredict_mask),
    .enq             (enq),
    .enq_uop         (sec_uop),
    .enq_br_mask     (bus.io_sec_br_mask),
    .enq_data        (bus.io_sec_data),
    .deq             (deq),
    .head_uop        (head_uop),
    .head_data       (head_data),
    .head_ok         (head_ok),
    .empty           (fifo_empty),
    .full            (fifo_full)
  );

  always_comb begin
    wb_uop_next  = wb_uop_reg;
    wb_data_next = wb_data_reg;
    wb_src_next  = wb_src_reg;
    if (exe_valid) begin
      wb_uop_next  = exe_uop;
      wb_data_next = bus.io_exe_data;
      wb_src_next  = 1'b0;
    end else if (sel_head) begin
      wb_uop_next  = head_uop;
      wb_data_next = head_data;
      wb_src_next  = 1'b1;
    end else if (sec_bypass) begin
      wb_uop_next  = sec_uop;
      wb_data_next = bus.io_sec_data;
      wb_src_next  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_valid_reg  <= 1'b0;
      wb_rf_wen_reg <= 1'b0;
      wb_uop_reg    <= '0;
      wb_data_reg   <= '0;
      wb_src_reg    <= 1'b0;
    end else begin
      wb_valid_reg  <= wb_sel;
      wb_rf_wen_reg <= wb_sel & writes_rf(wb_uop_next.dst_rtype);
      wb_uop_reg    <= wb_uop_next;
      wb_data_reg   <= wb_data_next;
      wb_src_reg    <= wb_src_next;
    end
  end

  assign bus.io_wb_valid     = wb_valid_reg;
  assign bus.io_wb_rf_wen    = wb_rf_wen_reg;
  assign bus.io_wb_rob_idx   = wb_uop_reg.rob_idx;
  assign bus.io_wb_pdst      = wb_uop_reg.pdst;
  assign bus.io_wb_dst_rtype = wb_uop_reg.dst_rtype;
  assign bus.io_wb_data      = wb_data_reg;
  assign bus.io_wb_src       = wb_src_reg;

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Directed bench for int_wb_arbiter: priority, queueing, kill, flush and reset.
module tb_int_wb_arbiter;
  import wb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clock = ~clock;

  int_wb_arbiter_if bus ();

  int_wb_arbiter #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc=%0d rst=%b wb_valid=%b src=%b rob=%0d pdst=%0d rf_wen=%b data=0x%0h sec_ready=%b",
             cyc, reset, bus.io_wb_valid, bus.io_wb_src, bus.io_wb_rob_idx, bus.io_wb_pdst,
             bus.io_wb_rf_wen, bus.io_wb_data, bus.io_sec_ready);
  endtask

  task automatic idle();
    bus.io_exe_valid = 1'b0;
    bus.io_exe_rob_idx = '0;
    bus.io_exe_pdst = '0;
    bus.io_exe_dst_rtype = '0;
    bus.io_exe_data = '0;
    bus.io_sec_valid = 1'b0;
    bus.io_sec_br_mask = '0;
    bus.io_sec_rob_idx = '0;
    bus.io_sec_pdst = '0;
    bus.io_sec_dst_rtype = '0;
    bus.io_sec_data = '0;
    bus.io_brupdate_b1_resolve_mask = '0;
    bus.io_brupdate_b1_mispredict_mask = '0;
    bus.io_flush = 1'b0;
  endtask

  task automatic exe(input logic [6:0] rob, input logic [6:0] pdst, input logic [1:0] rt,
                     input logic [64:0] d);
    bus.io_exe_valid = 1'b1;
    bus.io_exe_rob_idx = rob;
    bus.io_exe_pdst = pdst;
    bus.io_exe_dst_rtype = rt;
    bus.io_exe_data = d;
  endtask

  task automatic sec(input logic [19:0] m, input logic [6:0] rob, input logic [6:0] pdst,
                     input logic [1:0] rt, input logic [64:0] d);
    bus.io_sec_valid = 1'b1;
    bus.io_sec_br_mask = m;
    bus.io_sec_rob_idx = rob;
    bus.io_sec_pdst = pdst;
    bus.io_sec_dst_rtype = rt;
    bus.io_sec_data = d;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic src, input logic [6:0] rob,
                        input logic [64:0] d);
    chk({tag, ".valid"}, bus.io_wb_valid, v);
    if (v) begin
      chk({tag, ".src"}, bus.io_wb_src, src);
      chk({tag, ".rob"}, bus.io_wb_rob_idx, rob);
      chk({tag, ".data"}, bus.io_wb_data, d);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] exp);
    chk({tag, ".count"}, dut.u_fifo.count_reg, exp);
  endtask

  initial begin
    idle();
    // reset
    step();
    step();
    chk("rst.wb_valid", bus.io_wb_valid, 1'b0);
    chk("rst.rf_wen", bus.io_wb_rf_wen, 1'b0);
    chk("rst.data", bus.io_wb_data, 65'h0);
    chk("rst.sec_ready_low", bus.io_sec_ready, 1'b0);
    chk_cnt("rst", 3'd0);
    reset = 1'b1;
    #1;
    chk("rst.sec_ready_high", bus.io_sec_ready, 1'b1);

    // 1: plain exe writeback, then non-FIX rtype
    exe(7'd5, 7'd9, 2'd0, 65'h1234);
    step();
    chk_wb("t1", 1'b1, 1'b0, 7'd5, 65'h1234);
    chk("t1.pdst", bus.io_wb_pdst, 7'd9);
    chk("t1.rf_wen", bus.io_wb_rf_wen, 1'b1);
    exe(7'd6, 7'd10, 2'd1, 65'h55);
    step();
    chk_wb("t1b", 1'b1, 1'b0, 7'd6, 65'h55);
    chk("t1b.rf_wen", bus.io_wb_rf_wen, 1'b0);
    idle();
    step();
    chk("t1c.valid", bus.io_wb_valid, 1'b0);
    chk("t1c.rf_wen", bus.io_wb_rf_wen, 1'b0);

    // bypass: exe idle, FIFO empty
    sec(20'h0, 7'd3, 7'd4, 2'd0, 65'hB0);
    step();
    chk_wb("byp", 1'b1, 1'b1, 7'd3, 65'hB0);
    chk_cnt("byp", 3'd0);
    idle();

    // 2: exe and sec together -> sec queued, written next idle cycle
    exe(7'd1, 7'd1, 2'd0, 65'hA);
    sec(20'h0, 7'd2, 7'd3, 2'd0, 65'hB);
    step();
    chk_wb("t2a", 1'b1, 1'b0, 7'd1, 65'hA);
    chk_cnt("t2a", 3'd1);
    idle();
    step();
    chk_wb("t2b", 1'b1, 1'b1, 7'd2, 65'hB);
    chk_cnt("t2b", 3'd0);

    // 3: fill under continuous exe, then drain in order
    for (int i = 0; i < 4; i++) begin
      exe(7'(20 + i), 7'd1, 2'd0, 65'(256 + i));
      sec(20'h0, 7'(10 + i), 7'd2, 2'd0, 65'(16 + i));
      step();
      chk_wb("t3.fill", 1'b1, 1'b0, 7'(20 + i), 65'(256 + i));
    end
    chk("t3.ready_full", bus.io_sec_ready, 1'b0);
    chk_cnt("t3.full", 3'd4);
    exe(7'd30, 7'd1, 2'd0, 65'h130);
    sec(20'h0, 7'd14, 7'd2, 2'd0, 65'h99);
    step();
    chk_wb("t3.blocked", 1'b1, 1'b0, 7'd30, 65'h130);
    chk_cnt("t3.blocked", 3'd4);
    idle();
    step();
    chk_wb("t3.pop0", 1'b1, 1'b1, 7'd10, 65'h10);
    chk("t3.ready_after_pop", bus.io_sec_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_wb("t3.pop", 1'b1, 1'b1, 7'(10 + i), 65'(16 + i));
    end
    step();
    chk("t3.drained", bus.io_wb_valid, 1'b0);
    chk_cnt("t3.drained", 3'd0);

    // 4a: queued entry killed by mispredict -> silently popped
    exe(7'd40, 7'd1, 2'd0, 65'h400);
    sec(20'h4, 7'd41, 7'd2, 2'd0, 65'h40);
    step();
    chk_cnt("t4a.q", 3'd1);
    idle();
    exe(7'd42, 7'd1, 2'd0, 65'h420);
    bus.io_brupdate_b1_mispredict_mask = 20'h4;
    step();
    chk_wb("t4a.exe", 1'b1, 1'b0, 7'd42, 65'h420);
    idle();
    step();
    chk("t4a.no_wb", bus.io_wb_valid, 1'b0);
    chk_cnt("t4a.popped", 3'd0);

    // 4b: resolve clears the bit, a later mispredict on it no longer kills
    exe(7'd43, 7'd1, 2'd0, 65'h430);
    sec(20'h4, 7'd44, 7'd2, 2'd0, 65'h41);
    step();
    chk_cnt("t4b.q", 3'd1);
    idle();
    exe(7'd45, 7'd1, 2'd0, 65'h450);
    bus.io_brupdate_b1_resolve_mask = 20'h4;
    step();
    idle();
    exe(7'd46, 7'd1, 2'd0, 65'h460);
    bus.io_brupdate_b1_mispredict_mask = 20'h4;
    step();
    chk_wb("t4b.exe", 1'b1, 1'b0, 7'd46, 65'h460);
    chk_cnt("t4b.alive", 3'd1);
    idle();
    step();
    chk_wb("t4b.wb", 1'b1, 1'b1, 7'd44, 65'h41);

    // 4c: killed secondary on the bypass path is dropped
    sec(20'h8, 7'd47, 7'd2, 2'd0, 65'h47);
    bus.io_brupdate_b1_mispredict_mask = 20'h8;
    step();
    chk("t4c.no_wb", bus.io_wb_valid, 1'b0);
    chk_cnt("t4c", 3'd0);
    idle();

    // 5: flush with 3 queued; exe still written, sec fire dropped
    for (int i = 0; i < 3; i++) begin
      exe(7'(50 + i), 7'd1, 2'd0, 65'(1280 + i));
      sec(20'h0, 7'(60 + i), 7'd2, 2'd0, 65'(80 + i));
      step();
    end
    chk_cnt("t5.q", 3'd3);
    exe(7'd55, 7'd1, 2'd0, 65'h77);
    sec(20'h0, 7'd70, 7'd2, 2'd0, 65'h99);
    bus.io_flush = 1'b1;
    step();
    chk_wb("t5.exe", 1'b1, 1'b0, 7'd55, 65'h77);
    chk_cnt("t5.flushed", 3'd0);
    chk("t5.ready", bus.io_sec_ready, 1'b1);
    idle();
    step();
    chk("t5.no_sec", bus.io_wb_valid, 1'b0);

    // 6: reset mid-drain
    for (int i = 0; i < 3; i++) begin
      exe(7'(70 + i), 7'd1, 2'd0, 65'h700);
      sec(20'h0, 7'(80 + i), 7'd2, 2'd0, 65'(96 + i));
      step();
    end
    idle();
    step();
    chk_wb("t6.pop0", 1'b1, 1'b1, 7'd80, 65'h60);
    chk_cnt("t6.pop0", 3'd2);
    reset = 1'b0;
    step();
    chk("t6.rst_valid", bus.io_wb_valid, 1'b0);
    chk("t6.rst_data", bus.io_wb_data, 65'h0);
    chk_cnt("t6.rst", 3'd0);
    reset = 1'b1;
    step();
    chk("t6.after_valid", bus.io_wb_valid, 1'b0);
    chk("t6.after_ready", bus.io_sec_ready, 1'b1);
    exe(7'd90, 7'd1, 2'd0, 65'h88);
    step();
    chk_wb("t6.exe", 1'b1, 1'b0, 7'd90, 65'h88);
    idle();
    sec(20'h0, 7'd91, 7'd2, 2'd0, 65'h89);
    step();
    chk_wb("t6.byp", 1'b1, 1'b1, 7'd91, 65'h89);
    idle();
    step();
    chk("t6.end", bus.io_wb_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
